stab_packetizer: RTL and testbench
==================================

// Module: stab_packetizer
// PURPOSE
//  Upstream neighbour of the system stab port. Converts a raw payload word stream
//  into NoC packets: one HEAD flit, PKT_LEN BODY flits, one TAIL flit. Drives
//  data_i_stab/valid_i_stab and obeys ready_o_stab. Replaces the ROM-replay driver
//  with synthesizable framing.
// PARAMETERS
//  DW       `DW   flit width; bits [DW-1:DW-2] = type (`HEAD/`BODY/`TAIL), rest payload
//  PKT_LEN  64    BODY flits per packet, >=1
//  SEQ_W    16    packet sequence counter width, <= DW-2
// PORTS
//  clk        in   1      clock
//  rstn       in   1      async active-low reset
//  hdr_i      in   DW-2   head payload (dest/route info), sampled at packet start
//  pld_i      in   DW-2   payload word
//  pld_vld_i  in   1      payload valid
//  pld_rdy_o  out  1      payload accepted when pld_vld_i & pld_rdy_o
//  data_o     out  DW     flit to stab port
//  valid_o    out  1      flit valid
//  ready_i    in   1      downstream ready (ready_o_stab)
//  pkt_cnt_o  out  SEQ_W  completed packets (TAIL handshaked), wraps modulo 2^SEQ_W
//  busy_o     out  1      high from HEAD issue until TAIL handshake
// BEHAVIOUR
//  - Reset: data_o=0, valid_o=0, pld_rdy_o=0, pkt_cnt_o=0, busy_o=0, FSM=IDLE,
//    body counter=0. Reset mid-packet drops the partial packet; no TAIL is sent.
//  - Output is a single register stage: data_o/valid_o change only when
//    ~valid_o | ready_i ("slot free"). While valid_o & ~ready_i, data_o stays stable.
//  - FSM:
//    IDLE: if pld_vld_i & slot free -> load {`HEAD, hdr_i}, valid_o=1, busy_o=1,
//          go to BODY. The payload word is NOT consumed in this cycle.
//    BODY: pld_rdy_o = slot free. On pld_vld_i & pld_rdy_o, load {`BODY, pld_i} and
//          increment the body counter. The PKT_LEN-th accept goes to TAIL with
//          counter=0. No payload -> slot free causes valid_o=0 (bubble), state held.
//    TAIL: if slot free, load {`TAIL, {(DW-2-SEQ_W){0}}, pkt_cnt_o} and go to TAIL_W.
//    TAIL_W: on the TAIL handshake (valid_o & ready_i): pkt_cnt_o++, busy_o=0, go to
//          IDLE; the next HEAD may be loaded in that same cycle if pld_vld_i.
//  - pld_rdy_o is 0 in IDLE, TAIL and TAIL_W; combinational from state, valid_o, ready_i.
//  - Throughput: with continuous ready_i and valid payload, one flit per cycle;
//    a packet takes PKT_LEN+2 cycles. Latency pld accept -> flit on data_o: 1 cycle.
//  - hdr_i is sampled only in the IDLE->BODY transition cycle; later changes are ignored.
//  - ready_i low at any point only stalls; no flit is lost or duplicated.
//  - pkt_cnt_o wraps 2^SEQ_W-1 -> 0 with no flag.
// TESTING
//  1 Reset, PKT_LEN=4, ready_i=1, pld_vld_i=1, pld=1,2,3,4, hdr=0x5 -> flits
//    HEAD(0x5),BODY1..BODY4,TAIL(seq 0) on 6 consecutive cycles; pkt_cnt_o=1.
//  2 Back-pressure: ready_i low 3 cycles after BODY2 appears -> data_o holds BODY2,
//    pld_rdy_o=0 throughout; sequence resumes intact, no duplicate flits.
//  3 Payload gaps: pld_vld_i toggles 1/0 -> valid_o bubbles; 64 BODY flits per packet
//    exactly, TAIL only after the 64th, header type bits never corrupted.
//  4 Back-to-back: 3 packets with continuous input -> HEAD of packet n+1 in the cycle
//    after TAIL n handshakes; TAIL seq fields 0,1,2; pkt_cnt_o=3.
//  5 Reset asserted after BODY10 of packet 0 -> all outputs 0 next edge; after release
//    the first flit is HEAD, pkt_cnt_o=0.
//  6 SEQ_W=2, 5 packets -> TAIL seq fields 0,1,2,3,0; pkt_cnt_o ends at 1.

Source files
------------

// File: rtl/stab_packetizer.sv
// Frames a raw payload word stream into HEAD / PKT_LEN x BODY / TAIL NoC packets
// behind a single valid/ready output register stage.
module stab_packetizer #(
  parameter int unsigned DW      = 34,
  parameter int unsigned PKT_LEN = 64,
  parameter int unsigned SEQ_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DW-3:0]     hdr_i,
  input  logic [DW-3:0]     pld_i,
  input  logic              pld_vld_i,
  output logic              pld_rdy_o,
  output logic [DW-1:0]     data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [SEQ_W-1:0]  pkt_cnt_o,
  output logic              busy_o
);

  localparam int unsigned PW = DW - 2;
  localparam int unsigned CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [1:0]    TypeHead = 2'b10;
  localparam logic [1:0]    TypeBody = 2'b00;
  localparam logic [1:0]    TypeTail = 2'b01;
  localparam logic [CW-1:0] LastBody = CW'(PKT_LEN - 1);

  typedef enum logic [1:0] {StIdle, StBody, StTail, StTailW} state_e;

  state_e          state;
  logic [CW-1:0]   body_cnt;
  logic            slot_free;
  logic [PW-1:0]   seq_ext;

  assign slot_free = ~valid_o | ready_i;
  assign pld_rdy_o = (state == StBody) & slot_free;

  // TAIL payload carries the sequence number zero-extended to the payload width.
  always_comb begin
    seq_ext               = '0;
    seq_ext[SEQ_W-1:0]    = pkt_cnt_o;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= StIdle;
      body_cnt  <= '0;
      data_o    <= '0;
      valid_o   <= 1'b0;
      pkt_cnt_o <= '0;
      busy_o    <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (slot_free) begin
            if (pld_vld_i) begin
              data_o  <= {TypeHead, hdr_i};
              valid_o <= 1'b1;
              busy_o  <= 1'b1;
              state   <= StBody;
            end else begin
              valid_o <= 1'b0;
            end
          end
        end
        StBody: begin
          if (slot_free) begin
            if (pld_vld_i) begin
              data_o  <= {TypeBody, pld_i};
              valid_o <= 1'b1;
              if (body_cnt == LastBody) begin
                body_cnt <= '0;
                state    <= StTail;
              end else begin
                body_cnt <= body_cnt + 1'b1;
              end
            end else begin
              valid_o <= 1'b0;
            end
          end
        end
        StTail: begin
          if (slot_free) begin
            data_o  <= {TypeTail, seq_ext};
            valid_o <= 1'b1;
            state   <= StTailW;
          end
        end
        StTailW: begin
          // valid_o is always high here, so ready_i alone marks the TAIL handshake.
          if (ready_i) begin
            pkt_cnt_o <= pkt_cnt_o + 1'b1;
            if (pld_vld_i) begin
              data_o  <= {TypeHead, hdr_i};
              valid_o <= 1'b1;
              busy_o  <= 1'b1;
              state   <= StBody;
            end else begin
              valid_o <= 1'b0;
              busy_o  <= 1'b0;
              state   <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_stab_packetizer.sv
// Scoreboard bench for stab_packetizer: expected flits are queued when a packet is
// driven and popped on every output handshake.
module tb_stab_packetizer;

  localparam int unsigned DW      = 18;
  localparam int unsigned PW      = DW - 2;
  localparam int unsigned PKT_LEN = 4;
  localparam int unsigned SEQ_W   = 2;

  localparam logic [1:0] HEAD_T = 2'b10;
  localparam logic [1:0] BODY_T = 2'b00;
  localparam logic [1:0] TAIL_T = 2'b01;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PW-1:0]    hdr_i;
  logic [PW-1:0]    pld_i;
  logic             pld_vld_i;
  logic             pld_rdy_o;
  logic [DW-1:0]    data_o;
  logic             valid_o;
  logic             ready_i;
  logic [SEQ_W-1:0] pkt_cnt_o;
  logic             busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW-1:0]    exp_q[$];
  int               hs_cyc[$];
  logic [SEQ_W-1:0] seq_model;

  stab_packetizer #(
    .DW      (DW),
    .PKT_LEN (PKT_LEN),
    .SEQ_W   (SEQ_W)
  ) dut (
    .clk       (clk),
    .rstn      (rst_n),
    .hdr_i     (hdr_i),
    .pld_i     (pld_i),
    .pld_vld_i (pld_vld_i),
    .pld_rdy_o (pld_rdy_o),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .pkt_cnt_o (pkt_cnt_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("spurious_flit", 64'(data_o), 64'(0));
      else chk("flit", 64'(data_o), 64'(exp_q.pop_front()));
    end
  end

  task automatic send_pkt(input logic [PW-1:0] hdr, input logic [PW-1:0] base, input bit gap);
    logic [PW-1:0] seq_ext;
    int t;
    seq_ext            = '0;
    seq_ext[SEQ_W-1:0] = seq_model;
    exp_q.push_back({HEAD_T, hdr});
    for (int i = 0; i < PKT_LEN; i++) exp_q.push_back({BODY_T, base + PW'(i)});
    exp_q.push_back({TAIL_T, seq_ext});
    seq_model = seq_model + 1'b1;
    hdr_i = hdr;
    for (int i = 0; i < PKT_LEN; i++) begin
      if (gap && i > 0) begin
        pld_vld_i = 1'b0;
        @(posedge clk); #1;
      end
      pld_i     = base + PW'(i);
      pld_vld_i = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!pld_rdy_o && t < 200);
      if (!pld_rdy_o) begin
        chk("accept_timeout", 64'(pld_rdy_o), 64'(1));
        pld_vld_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (i == 0) hdr_i = ~hdr;  // HEAD is already out; later header changes must be ignored
    end
    pld_vld_i = 1'b0;
  endtask

  task automatic wait_flit(input string tag, input logic [DW-1:0] flit);
    int t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!(valid_o && data_o == flit) && t < 200);
    chk(tag, 64'(data_o), 64'(flit));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    pld_vld_i = 1'b0;
    ready_i   = 1'b1;
    exp_q.delete();
    seq_model = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    hs_cyc.delete();
  endtask

  task automatic stall_at_body2();
    wait_flit("t2_body2_seen", {BODY_T, PW'(2)});
    ready_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold", 64'(data_o), 64'({BODY_T, PW'(2)}));
      chk("t2_rdy_low", 64'(pld_rdy_o), 64'(0));
      chk("t2_busy", 64'(busy_o), 64'(1));
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ready_i = 1'b1; pld_vld_i = 1'b0; pld_i = '0; hdr_i = '0;
    seq_model = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 64'(data_o), 64'(0));
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_rdy", 64'(pld_rdy_o), 64'(0));
    chk("rst_cnt", 64'(pkt_cnt_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single packet, full throughput.
    hs_cyc.delete();
    send_pkt(PW'(5), PW'(1), 1'b0);
    drain();
    chk("t1_nflits", 64'(hs_cyc.size()), 64'(PKT_LEN + 2));
    if (hs_cyc.size() == PKT_LEN + 2) chk("t1_span", 64'(hs_cyc[PKT_LEN+1] - hs_cyc[0]),
                                          64'(PKT_LEN + 1));
    chk("t1_pkt_cnt", 64'(pkt_cnt_o), 64'(1));
    chk("t1_busy_off", 64'(busy_o), 64'(0));
    chk("t1_rdy_idle", 64'(pld_rdy_o), 64'(0));

    // Back-pressure in the middle of the body.
    fork
      send_pkt(PW'(16'h0a), PW'(1), 1'b0);
      stall_at_body2();
    join
    drain();
    chk("t2_pkt_cnt", 64'(pkt_cnt_o), 64'(2));

    // Payload gaps produce bubbles but exact framing.
    hs_cyc.delete();
    send_pkt(PW'(16'h33), PW'(16'h100), 1'b1);
    drain();
    chk("t3_nflits", 64'(hs_cyc.size()), 64'(PKT_LEN + 2));
    if (hs_cyc.size() == PKT_LEN + 2) chk("t3_span", 64'(hs_cyc[PKT_LEN+1] - hs_cyc[0]),
                                          64'(2 * PKT_LEN));
    chk("t3_pkt_cnt", 64'(pkt_cnt_o), 64'(3));

    // Back-to-back packets: no idle cycle between TAIL and next HEAD.
    apply_reset();
    for (int p = 0; p < 3; p++) send_pkt(PW'(16'h40 + p), PW'(16'h200 + 16 * p), 1'b0);
    drain();
    chk("t4_nflits", 64'(hs_cyc.size()), 64'(3 * (PKT_LEN + 2)));
    if (hs_cyc.size() == 3 * (PKT_LEN + 2))
      chk("t4_span", 64'(hs_cyc[3*(PKT_LEN+2)-1] - hs_cyc[0]), 64'(3 * (PKT_LEN + 2) - 1));
    chk("t4_pkt_cnt", 64'(pkt_cnt_o), 64'(3));

    // Reset mid-packet drops the partial packet.
    fork
      send_pkt(PW'(7), PW'(1), 1'b0);
      wait_flit("t5_body2_seen", {BODY_T, PW'(2)});
    join_any
    disable fork;
    rst_n = 1'b0;
    pld_vld_i = 1'b0;
    #1;
    chk("t5_data", 64'(data_o), 64'(0));
    chk("t5_valid", 64'(valid_o), 64'(0));
    chk("t5_rdy", 64'(pld_rdy_o), 64'(0));
    chk("t5_cnt", 64'(pkt_cnt_o), 64'(0));
    chk("t5_busy", 64'(busy_o), 64'(0));
    exp_q.delete();
    seq_model = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_cnt_after", 64'(pkt_cnt_o), 64'(0));
    send_pkt(PW'(9), PW'(16'h20), 1'b0);
    drain();
    chk("t5_pkt_cnt", 64'(pkt_cnt_o), 64'(1));

    // Sequence wrap with a 2-bit counter.
    apply_reset();
    for (int p = 0; p < 5; p++) send_pkt(PW'(16'h60 + p), PW'(16'h300 + 16 * p), 1'b0);
    drain();
    chk("t6_pkt_cnt", 64'(pkt_cnt_o), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
